uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
Parametrised UART receive engine and successor to the fixed 8-bit receiver. It takes the raw asynchronous serial line on the sys_clk domain and oversamples it x16 with mid-bit sampling. Each completed frame is delivered as a parallel word over a valid/ready handshake, with per-frame parity and framing flags, overrun and break detection. It sits between the pad and the host/FIFO side of the UART.

Parameters:
BAUD_DIV, 27, sys_clk cycles per oversample tick (x16 oversampling; 27 gives 115200 baud at 50 MHz); legal range 2..65535
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked, 1 or 2

Ports:
sys_clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
serial_data_in  input  1  raw serial line, idle high, asynchronous to sys_clk
rx_data  output  DATA_BITS  received word, valid while rx_valid=1
rx_valid  output  1  frame available
rx_ready  input  1  consumer accepts frame when rx_valid & rx_ready
parity_err  output  1  parity mismatch for current rx_data (qualified by rx_valid)
frame_err  output  1  a sampled stop bit was 0 for current rx_data (qualified by rx_valid)
overrun  output  1  one-cycle pulse: a frame was lost
break_det  output  1  one-cycle pulse: break condition detected
busy  output  1  receiver is inside a frame (state != IDLE)

Behaviour:
- Reset (async assert, sync release): all outputs 0; rx_data 0; synchroniser flops = 1; state IDLE; tick and bit counters 0.
- Input path: 2-flop synchroniser (reset value 1); all decisions use its output, so there is 2 cycles of input latency.
- Tick generator: counts 0..BAUD_DIV-1 and pulses tick for 1 cycle at wrap. It free-runs in IDLE and restarts at 0 on start-edge detection so phase aligns to the frame.
- Oversample counter os_cnt 0..15 advances on tick. The sample point is os_cnt==7; the bit boundary is os_cnt==15.
- States:
  - IDLE: synchronised line low on a tick -> START, os_cnt=0.
  - START: at sample point, line high -> IDLE (false start, no flags); line low -> continue to boundary -> DATA, bit_cnt=0.
  - DATA: at sample point, shift bit into shift register MSB-side (LSB first on line). At the boundary after bit DATA_BITS-1 -> PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: sample the parity bit. Error if XOR(data)^bit != (PARITY_MODE==2). Then -> STOP.
  - STOP: sample each stop bit; any 0 sets frame_err. The frame commits at the sample point of the last stop bit (not its boundary), giving half-bit resync margin. Then -> IDLE, or -> BREAK_WAIT on break.
  - BREAK_WAIT: wait for line high on a tick -> IDLE.
- Break: all data bits 0, parity bit (if any) 0 and first stop bit 0 -> break_det pulses 1 cycle at commit; the frame is not delivered (no rx_valid, no overrun); -> BREAK_WAIT.
- Output handshake:
  - On commit with rx_valid=0: the next cycle loads rx_data/parity_err/frame_err and sets rx_valid=1.
  - rx_valid and the associated data and flags hold stable until the cycle rx_valid & rx_ready; rx_valid then clears next cycle.
  - Commit while rx_valid=1 and no accept that cycle: new frame discarded, held frame kept, overrun pulses 1 cycle.
  - Commit in the same cycle as accept: new frame loaded, rx_valid stays 1, no overrun.
  - rx_ready while rx_valid=0 has no effect.
- Frames with frame_err or parity_err are still delivered, with the flags set.
- DATA_BITS<9: rx_data upper unused bits do not exist (width = DATA_BITS). The shift register is exactly DATA_BITS wide.
- busy = 1 from START entry through the commit cycle and during BREAK_WAIT.
- Reset mid-frame: immediate return to reset values; the partial frame is dropped; rx_valid cleared.

Decomposition:
- Shared package uart_pkg: PARITY_NONE/EVEN/ODD constants, rx state enum (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT), OVERSAMPLE=16, SAMPLE_POINT=7.
- One sub-module: uart_os_tick (BAUD_DIV counter with sync restart input, tick output).

Test Plan:
- BAUD_DIV=4, 8N1, send 0xA5, rx_ready=1 -> one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0; busy high about 9.5 bits (608 cycles).
- 8E1, send 0x07 with parity bit 0 (wrong) -> rx_data=0x07, parity_err=1; resend with parity 1 -> parity_err=0. 7O2 send 0x55 with correct parity -> no flags.
- Low glitch of 20 cycles (< half bit) on idle line -> START entered then IDLE; rx_valid, flags and overrun stay 0.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once at the second commit. Raise rx_ready -> 0x11 accepted, no 0x22.
- Line held low for 2 frame times -> break_det pulses once, frame_err not delivered, rx_valid=0, busy until line returns high; then 0x3C received correctly.
- Assert rst_n=0 mid DATA bit 4 of 0xFF -> all outputs 0 immediately. After release, a fresh 0x81 is received correctly and no stale frame appears.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive path.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  // x16 oversampling; the data bit is taken at the middle tick of each bit.
  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned SAMPLE_POINT = 7;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreakWait
  } rx_state_e;

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-cycle tick every BaudDiv clocks, phase
// re-alignable through restart_i.
module uart_os_tick #(
  parameter int unsigned BaudDiv = 27
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CntW = (BaudDiv > 2) ? $clog2(BaudDiv) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BaudDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: wrap at CntMax, or restart from zero on request.
  always_comb begin
    tick_o = (cnt_q == CntMax);
    cnt_d  = cnt_q + 1'b1;
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Divider counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: x16 oversampled, mid-bit sampled, configurable data
// width, parity and stop bits, with valid/ready delivery, overrun and break.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV    = 27,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 serial_data_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam logic       StopLast = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic [3:0] SampleOs = 4'(SAMPLE_POINT);
  localparam logic [3:0] LastOs   = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] LastBit  = 4'(DATA_BITS - 1);

  logic sync1_q, sync2_q, line;
  logic tick, restart, sample, boundary;

  rx_state_e            state_q, state_d;
  logic [3:0]           os_cnt_q, os_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 par_bit_q, par_bit_d;
  logic                 first_stop_q, first_stop_d;

  logic                 commit, commit_break, commit_ferr;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 break_det_q, break_det_d;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= serial_data_in;
      sync2_q <= sync1_q;
    end
  end

  assign line     = sync2_q;
  assign restart  = (state_q == StIdle) && tick && !line;
  assign sample   = tick && (os_cnt_q == SampleOs);
  assign boundary = tick && (os_cnt_q == LastOs);

  uart_os_tick #(
    .BaudDiv(BAUD_DIV)
  ) u_os_tick (
    .clk_i    (sys_clk),
    .rst_ni   (rst_n),
    .restart_i(restart),
    .tick_o   (tick)
  );

  // Frame FSM next-state: bit sequencing, sampling and commit decision.
  always_comb begin
    state_d      = state_q;
    os_cnt_d     = os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    stop_idx_d   = stop_idx_q;
    shift_d      = shift_q;
    perr_acc_d   = perr_acc_q;
    ferr_acc_d   = ferr_acc_q;
    par_bit_d    = par_bit_q;
    first_stop_d = first_stop_q;
    commit       = 1'b0;
    commit_break = 1'b0;
    commit_ferr  = ferr_acc_q;

    if (tick && (state_q != StIdle)) begin
      os_cnt_d = os_cnt_q + 4'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (tick && !line) begin
          state_d      = StStart;
          os_cnt_d     = 4'd0;
          perr_acc_d   = 1'b0;
          ferr_acc_d   = 1'b0;
          par_bit_d    = 1'b0;
          first_stop_d = 1'b1;
        end
      end
      StStart: begin
        if (sample && line) begin
          // Start bit gone by mid-bit: treat as a glitch.
          state_d = StIdle;
        end else if (boundary) begin
          state_d   = StData;
          bit_cnt_d = 4'd0;
        end
      end
      StData: begin
        if (sample) begin
          shift_d = {line, shift_q[DATA_BITS-1:1]};
        end
        if (boundary) begin
          if (bit_cnt_q == LastBit) begin
            state_d    = (PARITY_MODE != PARITY_NONE) ? StParity : StStop;
            stop_idx_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (sample) begin
          par_bit_d  = line;
          perr_acc_d = ((^shift_q) ^ line) != (PARITY_MODE == PARITY_ODD);
        end
        if (boundary) begin
          state_d    = StStop;
          stop_idx_d = 1'b0;
        end
      end
      StStop: begin
        if (sample) begin
          commit_ferr = ferr_acc_q | ~line;
          ferr_acc_d  = commit_ferr;
          if (stop_idx_q == 1'b0) begin
            first_stop_d = line;
          end
          if (stop_idx_q == StopLast) begin
            // Commit mid-way through the last stop bit to regain half a bit of margin.
            commit       = 1'b1;
            commit_break = (shift_q == '0) &&
                           ((PARITY_MODE == PARITY_NONE) || !par_bit_q) &&
                           !((stop_idx_q == 1'b0) ? line : first_stop_q);
            state_d      = commit_break ? StBreakWait : StIdle;
            os_cnt_d     = 4'd0;
          end
        end else if (boundary) begin
          stop_idx_d = 1'b1;
        end
      end
      StBreakWait: begin
        if (tick && line) begin
          state_d  = StIdle;
          os_cnt_d = 4'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame FSM and datapath registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      os_cnt_q     <= 4'd0;
      bit_cnt_q    <= 4'd0;
      stop_idx_q   <= 1'b0;
      shift_q      <= '0;
      perr_acc_q   <= 1'b0;
      ferr_acc_q   <= 1'b0;
      par_bit_q    <= 1'b0;
      first_stop_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_idx_q   <= stop_idx_d;
      shift_q      <= shift_d;
      perr_acc_q   <= perr_acc_d;
      ferr_acc_q   <= ferr_acc_d;
      par_bit_q    <= par_bit_d;
      first_stop_q <= first_stop_d;
    end
  end

  // Output holding register: accept, load on commit, or flag overrun/break.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    break_det_d  = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (commit) begin
      if (commit_break) begin
        break_det_d = 1'b1;
      end else if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        parity_err_d = perr_acc_q;
        frame_err_d  = commit_ferr;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      break_det_q  <= break_det_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign break_det  = break_det_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: three instances (8N1, 8E1, 7O2) at BAUD_DIV=4,
// random frames checked against a frame-level reference model.
module tb_uart_rx_core;

  localparam int Baud = 4;
  localparam int Bit  = 16 * Baud;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic line_a = 1'b1, line_b = 1'b1, line_c = 1'b1;
  logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic valid_a, perr_a, ferr_a, ovr_a, brk_a, busy_a;
  logic valid_b, perr_b, ferr_b, ovr_b, brk_b, busy_b;
  logic valid_c, perr_c, ferr_c, ovr_c, brk_c, busy_c;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_core #(.BAUD_DIV(Baud), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_a (
    .sys_clk(clk), .rst_n(rst_n), .serial_data_in(line_a), .rx_data(data_a),
    .rx_valid(valid_a), .rx_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a),
    .overrun(ovr_a), .break_det(brk_a), .busy(busy_a));

  uart_rx_core #(.BAUD_DIV(Baud), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_dut_b (
    .sys_clk(clk), .rst_n(rst_n), .serial_data_in(line_b), .rx_data(data_b),
    .rx_valid(valid_b), .rx_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b),
    .overrun(ovr_b), .break_det(brk_b), .busy(busy_b));

  uart_rx_core #(.BAUD_DIV(Baud), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u_dut_c (
    .sys_clk(clk), .rst_n(rst_n), .serial_data_in(line_c), .rx_data(data_c),
    .rx_valid(valid_c), .rx_ready(ready_c), .parity_err(perr_c), .frame_err(ferr_c),
    .overrun(ovr_c), .break_det(brk_c), .busy(busy_c));

  // Accepted frames as {parity_err, frame_err, data[8:0]}; pulse and busy tallies.
  logic [10:0] got_a[$], got_b[$], got_c[$];
  int ovr_cnt[3];
  int brk_cnt[3];
  int busy_cyc_a = 0;
  int stab_err   = 0;
  logic       hold_a = 1'b0;
  logic [7:0] hold_data_a = '0;

  initial begin
    for (int i = 0; i < 3; i++) begin
      ovr_cnt[i] = 0;
      brk_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (valid_a && ready_a) got_a.push_back({perr_a, ferr_a, 1'b0, data_a});
    if (valid_b && ready_b) got_b.push_back({perr_b, ferr_b, 1'b0, data_b});
    if (valid_c && ready_c) got_c.push_back({perr_c, ferr_c, 2'b00, data_c});
    if (ovr_a) ovr_cnt[0]++;
    if (ovr_b) ovr_cnt[1]++;
    if (ovr_c) ovr_cnt[2]++;
    if (brk_a) brk_cnt[0]++;
    if (brk_b) brk_cnt[1]++;
    if (brk_c) brk_cnt[2]++;
    if (busy_a) busy_cyc_a++;
    if (hold_a && valid_a && rst_n && (data_a !== hold_data_a)) stab_err++;
    hold_a      = valid_a && !ready_a;
    hold_data_a = data_a;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v);
    case (sel)
      0:       line_a = v;
      1:       line_b = v;
      default: line_c = v;
    endcase
  endtask

  function automatic int got_n(input int sel);
    case (sel)
      0:       return got_a.size();
      1:       return got_b.size();
      default: return got_c.size();
    endcase
  endfunction

  function automatic logic [10:0] got_at(input int sel, input int idx);
    case (sel)
      0:       return got_a[idx];
      1:       return got_b[idx];
      default: return got_c[idx];
    endcase
  endfunction

  // Serialise one frame LSB first, then idle high for gap bit times.
  task automatic send_frame(input int sel, input int nbits, input int pmode, input int nstop,
                            input logic [8:0] data, input logic pbit, input logic [1:0] stopv,
                            input int gap);
    drive(sel, 1'b0);
    cycles(Bit);
    for (int i = 0; i < nbits; i++) begin
      drive(sel, data[i]);
      cycles(Bit);
    end
    if (pmode != 0) begin
      drive(sel, pbit);
      cycles(Bit);
    end
    for (int s = 0; s < nstop; s++) begin
      drive(sel, stopv[s]);
      cycles(Bit);
    end
    drive(sel, 1'b1);
    cycles(gap * Bit);
  endtask

  // Reference: what the receiver should report for a frame, from the line rules.
  task automatic model(input int nbits, input int pmode, input int nstop, input logic [8:0] data,
                       input logic pbit, input logic [1:0] stopv,
                       output logic is_brk, output logic [10:0] word);
    logic [8:0] d;
    int   ones;
    logic perr, ferr;
    d    = data & 9'((1 << nbits) - 1);
    ones = $countones(d) + int'(pbit);
    if (pmode == 0)      perr = 1'b0;
    else if (pmode == 1) perr = (ones % 2) != 0;
    else                 perr = (ones % 2) != 1;
    ferr   = (stopv[0] == 1'b0) || (nstop == 2 && stopv[1] == 1'b0);
    is_brk = (d == 9'd0) && (pmode == 0 || pbit == 1'b0) && (stopv[0] == 1'b0);
    word   = {perr, ferr, d};
  endtask

  task automatic test_reset();
    cycles(3);
    n_checks++; if ({valid_a, perr_a, ferr_a, ovr_a, brk_a, busy_a} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags_a: got %b expected 000000",
                         {valid_a, perr_a, ferr_a, ovr_a, brk_a, busy_a});
    end
    n_checks++; if (data_a !== 8'h00) begin
      n_fail++; $display("FAIL reset_data_a: got %h expected 00", data_a);
    end
    n_checks++; if ({valid_b, busy_b, valid_c, busy_c, data_c} !== 11'b0) begin
      n_fail++; $display("FAIL reset_bc: got %b expected 0", {valid_b, busy_b, valid_c, busy_c, data_c});
    end
    rst_n = 1'b1;
    cycles(10);
    n_checks++; if ({valid_a, busy_a, valid_b, busy_b, valid_c, busy_c} !== 6'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got %b expected 000000",
                         {valid_a, busy_a, valid_b, busy_b, valid_c, busy_c});
    end
  endtask

  task automatic test_basic_8n1();
    int base = got_n(0);
    int b0   = busy_cyc_a;
    send_frame(0, 8, 0, 1, 9'h0A5, 1'b0, 2'b11, 2);
    n_checks++; if (got_n(0) - base !== 1) begin
      n_fail++; $display("FAIL basic_count: got %0d frames expected 1", got_n(0) - base);
    end else begin
      n_checks++; if (got_at(0, base) !== 11'h0A5) begin
        n_fail++; $display("FAIL basic_word: got %h expected 0a5", got_at(0, base));
      end
    end
    n_checks++; if (busy_cyc_a - b0 < 600 || busy_cyc_a - b0 > 616) begin
      n_fail++; $display("FAIL basic_busy_len: got %0d cycles expected about 608", busy_cyc_a - b0);
    end
  endtask

  task automatic run_random(input int sel, input int nbits, input int pmode, input int nstop,
                            input int n, input string tag);
    logic [10:0] exp_q[$];
    int   base  = got_n(sel);
    int   bbase = brk_cnt[sel];
    int   obase = ovr_cnt[sel];
    int   exp_brk = 0;
    for (int k = 0; k < n; k++) begin
      logic [8:0]  d;
      logic        pbit, is_brk;
      logic [1:0]  stopv;
      logic [10:0] w;
      d = 9'($urandom) & 9'((1 << nbits) - 1);
      if ($urandom_range(0, 7) == 0) d = 9'd0;
      pbit = ((pmode == 1) ? ($countones(d) % 2 == 1) : ($countones(d) % 2 == 0));
      if ($urandom_range(0, 3) == 0) pbit = ~pbit;
      stopv[0] = ($urandom_range(0, 3) != 0);
      stopv[1] = ($urandom_range(0, 3) != 0);
      model(nbits, pmode, nstop, d, pbit, stopv, is_brk, w);
      if (is_brk) exp_brk++;
      else exp_q.push_back(w);
      send_frame(sel, nbits, pmode, nstop, d, pbit, stopv, 2);
    end
    n_checks++; if (got_n(sel) - base !== exp_q.size()) begin
      n_fail++; $display("FAIL %s_count: got %0d frames expected %0d", tag, got_n(sel) - base,
                         exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++; if (got_at(sel, base + i) !== exp_q[i]) begin
          n_fail++; $display("FAIL %s_word%0d: got %h expected %h", tag, i,
                             got_at(sel, base + i), exp_q[i]);
        end
      end
    end
    n_checks++; if (brk_cnt[sel] - bbase !== exp_brk) begin
      n_fail++; $display("FAIL %s_break: got %0d expected %0d", tag, brk_cnt[sel] - bbase, exp_brk);
    end
    n_checks++; if (ovr_cnt[sel] - obase !== 0) begin
      n_fail++; $display("FAIL %s_overrun: got %0d expected 0", tag, ovr_cnt[sel] - obase);
    end
  endtask

  task automatic test_parity();
    int base_b = got_n(1);
    int base_c = got_n(2);
    send_frame(1, 8, 1, 1, 9'h007, 1'b0, 2'b11, 2);
    send_frame(1, 8, 1, 1, 9'h007, 1'b1, 2'b11, 2);
    send_frame(2, 7, 2, 2, 9'h055, 1'b1, 2'b11, 2);
    n_checks++; if (got_n(1) - base_b !== 2 || got_n(2) - base_c !== 1) begin
      n_fail++; $display("FAIL parity_count: got %0d/%0d expected 2/1", got_n(1) - base_b,
                         got_n(2) - base_c);
    end else begin
      n_checks++; if (got_at(1, base_b) !== 11'h407) begin
        n_fail++; $display("FAIL parity_bad: got %h expected 407", got_at(1, base_b));
      end
      n_checks++; if (got_at(1, base_b + 1) !== 11'h007) begin
        n_fail++; $display("FAIL parity_good: got %h expected 007", got_at(1, base_b + 1));
      end
      n_checks++; if (got_at(2, base_c) !== 11'h055) begin
        n_fail++; $display("FAIL parity_7o2: got %h expected 055", got_at(2, base_c));
      end
    end
  endtask

  task automatic test_glitch();
    int   base  = got_n(0);
    int   obase = ovr_cnt[0];
    int   bbase = brk_cnt[0];
    logic saw   = 1'b0;
    drive(0, 1'b0);
    cycles(20);
    drive(0, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (busy_a) saw = 1'b1;
      cycles(1);
    end
    n_checks++; if (saw !== 1'b1) begin
      n_fail++; $display("FAIL glitch_start: got busy_seen=%b expected 1", saw);
    end
    n_checks++; if ({busy_a, valid_a} !== 2'b00) begin
      n_fail++; $display("FAIL glitch_idle: got busy,valid=%b expected 00", {busy_a, valid_a});
    end
    n_checks++; if (got_n(0) - base + ovr_cnt[0] - obase + brk_cnt[0] - bbase !== 0) begin
      n_fail++; $display("FAIL glitch_events: got %0d expected 0",
                         got_n(0) - base + ovr_cnt[0] - obase + brk_cnt[0] - bbase);
    end
  endtask

  task automatic test_overrun();
    int base  = got_n(0);
    int obase = ovr_cnt[0];
    int s0    = stab_err;
    ready_a = 1'b0;
    send_frame(0, 8, 0, 1, 9'h011, 1'b0, 2'b11, 2);
    send_frame(0, 8, 0, 1, 9'h022, 1'b0, 2'b11, 2);
    n_checks++; if ({valid_a, data_a} !== {1'b1, 8'h11}) begin
      n_fail++; $display("FAIL overrun_hold: got valid=%b data=%h expected 1 11", valid_a, data_a);
    end
    n_checks++; if (ovr_cnt[0] - obase !== 1) begin
      n_fail++; $display("FAIL overrun_pulse: got %0d expected 1", ovr_cnt[0] - obase);
    end
    n_checks++; if (stab_err - s0 !== 0) begin
      n_fail++; $display("FAIL overrun_stable: got %0d changes expected 0", stab_err - s0);
    end
    ready_a = 1'b1;
    cycles(5);
    n_checks++; if (got_n(0) - base !== 1) begin
      n_fail++; $display("FAIL overrun_accept_count: got %0d expected 1", got_n(0) - base);
    end else begin
      n_checks++; if (got_at(0, base) !== 11'h011) begin
        n_fail++; $display("FAIL overrun_accept: got %h expected 011", got_at(0, base));
      end
    end
    n_checks++; if (valid_a !== 1'b0) begin
      n_fail++; $display("FAIL overrun_clear: got %b expected 0", valid_a);
    end
  endtask

  task automatic test_break();
    int base  = got_n(0);
    int bbase = brk_cnt[0];
    drive(0, 1'b0);
    cycles(20 * Bit);
    n_checks++; if ({busy_a, valid_a} !== 2'b10) begin
      n_fail++; $display("FAIL break_wait: got busy,valid=%b expected 10", {busy_a, valid_a});
    end
    drive(0, 1'b1);
    cycles(20);
    n_checks++; if (busy_a !== 1'b0) begin
      n_fail++; $display("FAIL break_release: got busy=%b expected 0", busy_a);
    end
    n_checks++; if (brk_cnt[0] - bbase !== 1 || got_n(0) - base !== 0) begin
      n_fail++; $display("FAIL break_pulse: got breaks=%0d frames=%0d expected 1 0",
                         brk_cnt[0] - bbase, got_n(0) - base);
    end
    send_frame(0, 8, 0, 1, 9'h03C, 1'b0, 2'b11, 2);
    n_checks++; if (got_n(0) - base !== 1 || got_at(0, base) !== 11'h03C) begin
      n_fail++; $display("FAIL break_after: got %0d frames first %h expected 1 03c",
                         got_n(0) - base, got_at(0, base));
    end
  endtask

  task automatic test_reset_mid();
    int base;
    ready_a = 1'b0;
    send_frame(0, 8, 0, 1, 9'h05A, 1'b0, 2'b11, 2);
    n_checks++; if (valid_a !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre_valid: got %b expected 1", valid_a);
    end
    drive(0, 1'b0);
    cycles(Bit);
    drive(0, 1'b1);
    cycles(4 * Bit + Bit / 2);
    n_checks++; if (busy_a !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre_busy: got %b expected 1", busy_a);
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({valid_a, perr_a, ferr_a, ovr_a, brk_a, busy_a, data_a} !== 14'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %b expected 0",
                         {valid_a, perr_a, ferr_a, ovr_a, brk_a, busy_a, data_a});
    end
    cycles(4);
    rst_n   = 1'b1;
    ready_a = 1'b1;
    base    = got_n(0);
    cycles(12 * Bit);
    n_checks++; if (got_n(0) - base !== 0) begin
      n_fail++; $display("FAIL rstmid_stale: got %0d frames expected 0", got_n(0) - base);
    end
    send_frame(0, 8, 0, 1, 9'h081, 1'b0, 2'b11, 2);
    n_checks++; if (got_n(0) - base !== 1 || got_at(0, base) !== 11'h081) begin
      n_fail++; $display("FAIL rstmid_fresh: got %0d frames first %h expected 1 081",
                         got_n(0) - base, got_at(0, base));
    end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    run_random(0, 8, 0, 1, 6, "rand_8n1");
    test_parity();
    run_random(1, 8, 1, 1, 6, "rand_8e1");
    run_random(2, 7, 2, 2, 6, "rand_7o2");
    test_glitch();
    test_overrun();
    test_break();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
